// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums a frame of 64-bit signed products arriving on a valid/ready
//   handshake. A frame closes on in_last or on the MAX_TERMS-th accepted
//   product. The result is then presented on a held output handshake
//   until it is consumed.
//
//   Optional build macro: PRODUCT_ACC_SATURATE_EN
//     defined   - signed overflow clamps the running sum to the most
//                 positive / most negative value; out_overflow still sets
//     undefined - the running sum wraps modulo 2^DATA_W
//
//   clear is a synchronous frame abort. rst_n is a synchronous active-low
//   reset and has priority over clear.
module product_accumulator #(
    parameter int DATA_W    = 64,
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  MAX_TERMS_C = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [DATA_W-1:0] ACC_ZERO    = {DATA_W{1'b0}};
`ifdef PRODUCT_ACC_SATURATE_EN
    localparam logic [DATA_W-1:0] SAT_MAX     = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN     = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    // Two's-complement add overflow: operands agree in sign, result does not.
    function automatic logic add_overflow(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] s
    );
        return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    logic [DATA_W-1:0]   acc_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                ovf_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_sum_r;
    logic [CNT_W-1:0]    out_count_r;
    logic                out_overflow_r;

    logic                in_ready_s;
    logic                accept_s;
    logic                closing_s;
    logic [DATA_W-1:0]   base_acc_s;
    logic [DATA_W-1:0]   raw_sum_s;
    logic                add_ovf_s;
    logic [DATA_W-1:0]   sum_next_s;
    logic [CNT_W-1:0]    cnt_next_s;
    logic                ovf_next_s;

    // Ready is a pure decode of the state register, independent of in_valid.
    assign in_ready_s   = (state_r != HOLD);
    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_sum      = out_sum_r;
    assign out_count    = out_count_r;
    assign out_overflow = out_overflow_r;

    // Datapath for an accepted product: the first term of a frame starts from zero.
    always_comb begin
        accept_s   = in_valid & in_ready_s;
        base_acc_s = (state_r == IDLE) ? ACC_ZERO : acc_r;
        raw_sum_s  = base_acc_s + in_product;
        add_ovf_s  = add_overflow(base_acc_s, in_product, raw_sum_s);
`ifdef PRODUCT_ACC_SATURATE_EN
        if (add_ovf_s) begin
            // Operands share a sign on overflow, so the running sum's sign picks the rail.
            if (base_acc_s[DATA_W-1]) begin
                sum_next_s = SAT_MIN;
            end else begin
                sum_next_s = SAT_MAX;
            end
        end else begin
            sum_next_s = raw_sum_s;
        end
`else
        sum_next_s = raw_sum_s;
`endif
        cnt_next_s = (state_r == IDLE) ? CNT_ONE : (cnt_r + CNT_ONE);
        ovf_next_s = ((state_r == IDLE) ? 1'b0 : ovf_r) | add_ovf_s;
        // in_last on the MAX_TERMS-th term is still a single close.
        closing_s  = accept_s & (in_last | (cnt_next_s == MAX_TERMS_C));
    end

    // Next-state logic; clear forces IDLE over any accept or output handshake.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE, ACCUM: begin
                if (closing_s) begin
                    state_nx_s = HOLD;
                end else if (accept_s) begin
                    state_nx_s = ACCUM;
                end else begin
                    state_nx_s = state_r;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
        if (clear) begin
            state_nx_s = IDLE;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Accumulator, term counter, sticky overflow and the registered frame result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r          <= ACC_ZERO;
            cnt_r          <= {CNT_W{1'b0}};
            ovf_r          <= 1'b0;
            out_valid_r    <= 1'b0;
            out_sum_r      <= ACC_ZERO;
            out_count_r    <= {CNT_W{1'b0}};
            out_overflow_r <= 1'b0;
        end else if (clear) begin
            // Abort: drop the partial frame and any held result; last result fields stay.
            acc_r       <= ACC_ZERO;
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (state_r == HOLD) begin
            if (out_ready) begin
                acc_r       <= ACC_ZERO;
                cnt_r       <= {CNT_W{1'b0}};
                ovf_r       <= 1'b0;
                out_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            acc_r <= sum_next_s;
            cnt_r <= cnt_next_s;
            ovf_r <= ovf_next_s;
            if (closing_s) begin
                out_valid_r    <= 1'b1;
                out_sum_r      <= sum_next_s;
                out_count_r    <= cnt_next_s;
                out_overflow_r <= ovf_next_s;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and back-pressured random checks for product_accumulator.
// Inputs are driven 1 time unit after each rising edge; outputs are
// sampled at the same point, after the edge has settled.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_product;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic [7:0]  out_count;
    logic        out_overflow;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_product   (in_product),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [63:0] p, input logic l);
        in_valid   = v;
        in_product = p;
        in_last    = l;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    logic [63:0] exp_ovf_sum;
    logic [63:0] rnd;
    logic [63:0] prod;
    logic [63:0] msum;
    int          mcnt;
    logic        mhold;
    logic        mhold_nx;
    logic        iv;
    logic        il;
    logic        ordy;
    int          frames;
    int          cycles;
    logic [63:0] q_sum[$];
    int          q_cnt[$];

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        put(1'b0, 64'd0, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Reset values
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_overflow", 64'(out_overflow), 64'd0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_out_valid", 64'(out_valid), 64'd0);
            chk("idle_in_ready", 64'(in_ready), 64'd1);
            chk("idle_out_sum", out_sum, 64'd0);
        end

        // Frame 6, -15, 100 -> 91
        put(1'b1, 64'd6, 1'b0);
        cyc();
        put(1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        cyc();
        put(1'b1, 64'd100, 1'b1);
        cyc();
        put(1'b0, 64'd0, 1'b0);
        chk("f1_out_valid", 64'(out_valid), 64'd1);
        chk("f1_out_sum", out_sum, 64'd91);
        chk("f1_out_count", 64'(out_count), 64'd3);
        chk("f1_out_overflow", 64'(out_overflow), 64'd0);
        chk("f1_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("f1_hold_valid", 64'(out_valid), 64'd1);
            chk("f1_hold_sum", out_sum, 64'd91);
            chk("f1_hold_count", 64'(out_count), 64'd3);
            chk("f1_hold_in_ready", 64'(in_ready), 64'd0);
        end
        handshake();
        chk("f1_post_valid", 64'(out_valid), 64'd0);
        chk("f1_post_in_ready", 64'(in_ready), 64'd1);
        chk("f1_post_sum_held", out_sum, 64'd91);

        // Reset in the middle of a frame after 3 terms
        put(1'b1, 64'd1, 1'b0);
        cyc();
        put(1'b1, 64'd2, 1'b0);
        cyc();
        put(1'b1, 64'd3, 1'b0);
        cyc();
        put(1'b0, 64'd0, 1'b0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_out_sum", out_sum, 64'd0);
        put(1'b1, 64'd10, 1'b1);
        cyc();
        put(1'b0, 64'd0, 1'b0);
        chk("mrst_f_valid", 64'(out_valid), 64'd1);
        chk("mrst_f_sum", out_sum, 64'd10);
        chk("mrst_f_count", 64'(out_count), 64'd1);
        handshake();

        // Sixteen ones close the frame; a 17th product waits
        for (int i = 0; i < 16; i++) begin
            put(1'b1, 64'd1, 1'b0);
            cyc();
        end
        put(1'b1, 64'd5, 1'b1);
        chk("max_out_valid", 64'(out_valid), 64'd1);
        chk("max_out_sum", out_sum, 64'd16);
        chk("max_out_count", 64'(out_count), 64'd16);
        chk("max_in_ready", 64'(in_ready), 64'd0);
        cyc();
        chk("max_hold_valid", 64'(out_valid), 64'd1);
        chk("max_hold_sum", out_sum, 64'd16);
        handshake();
        chk("max_post_valid", 64'(out_valid), 64'd0);
        chk("max_post_in_ready", 64'(in_ready), 64'd1);
        cyc();
        put(1'b0, 64'd0, 1'b0);
        chk("t17_valid", 64'(out_valid), 64'd1);
        chk("t17_sum", out_sum, 64'd5);
        chk("t17_count", 64'(out_count), 64'd1);
        handshake();

        // in_last on the 16th term closes once
        for (int i = 0; i < 16; i++) begin
            put(1'b1, 64'd2, (i == 15));
            cyc();
        end
        put(1'b0, 64'd0, 1'b0);
        chk("lastmax_valid", 64'(out_valid), 64'd1);
        chk("lastmax_sum", out_sum, 64'd32);
        chk("lastmax_count", 64'(out_count), 64'd16);
        handshake();
        chk("lastmax_post_valid", 64'(out_valid), 64'd0);
        cyc();
        chk("lastmax_no_reclose", 64'(out_valid), 64'd0);

        // Positive overflow
`ifdef PRODUCT_ACC_SATURATE_EN
        exp_ovf_sum = 64'h7FFF_FFFF_FFFF_FFFF;
`else
        exp_ovf_sum = 64'h8000_0000_0000_0000;
`endif
        put(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        cyc();
        put(1'b1, 64'd1, 1'b1);
        cyc();
        put(1'b0, 64'd0, 1'b0);
        chk("ovf_valid", 64'(out_valid), 64'd1);
        chk("ovf_sum", out_sum, exp_ovf_sum);
        chk("ovf_flag", 64'(out_overflow), 64'd1);
        chk("ovf_count", 64'(out_count), 64'd2);
        handshake();

        // clear on the 2nd term drops it
        put(1'b1, 64'd5, 1'b0);
        cyc();
        put(1'b1, 64'd7, 1'b0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        put(1'b0, 64'd0, 1'b0);
        chk("clr_in_ready", 64'(in_ready), 64'd1);
        chk("clr_out_valid", 64'(out_valid), 64'd0);
        put(1'b1, 64'd4, 1'b1);
        cyc();
        put(1'b0, 64'd0, 1'b0);
        chk("clr_f_valid", 64'(out_valid), 64'd1);
        chk("clr_f_sum", out_sum, 64'd4);
        chk("clr_f_count", 64'(out_count), 64'd1);
        chk("clr_f_overflow", 64'(out_overflow), 64'd0);
        // clear while holding a result discards it
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_hold_valid", 64'(out_valid), 64'd0);
        chk("clr_hold_in_ready", 64'(in_ready), 64'd1);

        // Random back-pressure, 200 frames of small signed products (no overflow)
        msum   = 64'd0;
        mcnt   = 0;
        mhold  = 1'b0;
        frames = 0;
        cycles = 0;
        while (frames < 200 && cycles < 20000) begin
            chk("rnd_in_ready", 64'(in_ready), 64'(!mhold));
            chk("rnd_out_valid", 64'(out_valid), 64'(mhold));
            iv   = ($urandom_range(3) != 0);
            il   = ($urandom_range(4) == 0);
            ordy = ($urandom_range(2) != 0);
            rnd  = {$urandom(), $urandom()};
            prod = {{16{rnd[47]}}, rnd[47:0]};
            put(iv, prod, il);
            out_ready = ordy;
            mhold_nx  = mhold;
            if (mhold) begin
                if (ordy) begin
                    chk("rnd_sum", out_sum, q_sum.pop_front());
                    chk("rnd_count", 64'(out_count), 64'(q_cnt.pop_front()));
                    frames++;
                    mhold_nx = 1'b0;
                end
            end else if (iv) begin
                msum = msum + prod;
                mcnt++;
                if (il || mcnt == 16) begin
                    q_sum.push_back(msum);
                    q_cnt.push_back(mcnt);
                    msum     = 64'd0;
                    mcnt     = 0;
                    mhold_nx = 1'b1;
                end
            end
            cyc();
            mhold = mhold_nx;
            cycles++;
        end
        chk("rnd_frames_done", 64'(frames), 64'd200);
        put(1'b0, 64'd0, 1'b0);
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 32x32 signed multiplier.
- Accepts 64-bit two's-complement products over a valid/ready handshake and sums them into a 64-bit signed accumulator.
- A frame ends on `in_last` or after MAX_TERMS products. The frame result is then presented on a held output handshake until consumed.
- Provides the multiply-accumulate path for dot-product style workloads.

Parameters:
- DATA_W, 64, width of product input and accumulator.
- MAX_TERMS, 16, maximum products per frame; a frame closes automatically on the MAX_TERMS-th accept.
- CNT_W, 8, width of the term counter and `out_count`; MAX_TERMS must be ≤ 2^CNT_W − 1.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- clear  input  1  synchronous frame abort
- in_valid  input  1  product valid from multiplier stage
- in_ready  output  1  stage can accept a product
- in_product  input  DATA_W  signed product
- in_last  input  1  product is last of frame
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  DATA_W  signed frame sum
- out_count  output  CNT_W  number of products in frame
- out_overflow  output  1  sticky: signed overflow occurred in frame

Behaviour:
- Interface: one clock (`clk`); reset is synchronous and active-low (`rst_n`), sampled on the rising edge of `clk`.
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_overflow`=0.
  - Internal acc=0, cnt=0, ovf=0, state=IDLE.
- States: IDLE (no terms yet), ACCUM (≥1 term accepted), HOLD (result presented).
- `in_ready` = 1 in IDLE/ACCUM, 0 in HOLD. It is combinational from state only, never from `in_valid`.
- Accept = `in_valid` & `in_ready`. On accept:
  - sum_next = (IDLE ? 0 : acc) + `in_product`, full DATA_W two's-complement.
  - cnt_next = (IDLE ? 1 : cnt+1).
  - ovf_next = (IDLE ? 0 : ovf) | signed overflow of the add.
  - Signed overflow = both addend MSBs equal and sum MSB differs.
- Transitions:
  - IDLE, accept, not closing → ACCUM.
  - IDLE/ACCUM, accept with `in_last`=1 or cnt_next==MAX_TERMS → HOLD.
  - HOLD with `out_ready`=1 → IDLE.
  - No accept: state holds.
- Latency: `out_valid`=1 and `out_sum`/`out_count`/`out_overflow` registered and valid in the cycle after the closing accept (1-cycle latency).
- HOLD: outputs stable while `out_valid`=1 and `out_ready`=0. On the handshake cycle, the next cycle has `out_valid`=0, `in_ready`=1, acc/cnt/ovf=0.
- No bubble removal: a product offered in the handshake cycle is not accepted (`in_ready`=0 in HOLD). It is accepted earliest the following cycle.
- Outside HOLD, `out_sum`/`out_count`/`out_overflow` hold their last presented values; only `out_valid` qualifies them.
- `clear`=1 (rst_n=1): next cycle state=IDLE, acc/cnt/ovf=0, `out_valid`=0.
  - A product offered in the `clear` cycle is dropped.
  - A result in HOLD is discarded.
  - `clear` has priority over accept and output handshake; `rst_n` has priority over `clear`.
- Reset mid-frame or mid-HOLD: all state returns to reset values next edge; partial sum discarded.
- `in_last`=1 on a product that also reaches MAX_TERMS: single close, no double count.
- MAX_TERMS=1: every accept closes a frame.
- Zero products (e.g. 0 × anything from the multiplier) are counted as terms.

Optional Feature:
- Macro: PRODUCT_ACC_SATURATE_EN.
- Defined: on signed overflow the accumulator clamps instead of wrapping, and `out_overflow` still sets.
  - Positive overflow → 2^(DATA_W−1)−1.
  - Negative overflow → −2^(DATA_W−1).
  - Subsequent terms add to the clamped value with the same rule.
- Undefined: wrap-around modulo 2^DATA_W, `out_overflow` sticky as specified.

Test Plan:
- Reset then idle → `out_valid`=0, `in_ready`=1, `out_sum`=0 for 10 cycles. `rst_n` low for 1 cycle mid-ACCUM after 3 terms → next cycle `in_ready`=1, next frame sum starts from 0.
- Frame of products 6, −15, 100 with `in_last` on 100 → one cycle later `out_sum`=91, `out_count`=3, `out_overflow`=0. Hold `out_ready`=0 for 5 cycles → outputs stable, `in_ready`=0.
- 16 products of 1 with no `in_last` (MAX_TERMS=16) → auto-close, `out_sum`=16, `out_count`=16; 17th product waits until after the output handshake.
- Products 0x7FFF_FFFF_FFFF_FFFF then 1 with `in_last` → without macro `out_sum`=0x8000_0000_0000_0000, `out_overflow`=1. With PRODUCT_ACC_SATURATE_EN: `out_sum`=0x7FFF_FFFF_FFFF_FFFF, `out_overflow`=1.
- `clear` asserted with `in_valid` on the 2nd term of a frame (terms 5, 7) → term dropped, state IDLE. Next frame 4 with `in_last` → `out_sum`=4, `out_count`=1.
- Random `in_valid`/`out_ready` back-pressure over 200 frames of random signed products → `out_sum` matches a reference 64-bit sum per frame; no product lost or duplicated.
